// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline registers.
// Holds the EX/MEM payload layout and the MemtoReg encodings.
package mips_pkg;

   localparam int DATA_W  = 32;
   localparam int PC_W    = 32;
   localparam int RADDR_W = 5;
   localparam int SEL_W   = 2;

   localparam logic [SEL_W-1:0] MTR_ALU = 2'd0;
   localparam logic [SEL_W-1:0] MTR_MEM = 2'd1;
   localparam logic [SEL_W-1:0] MTR_PC  = 2'd2;

   typedef struct packed {
      logic [DATA_W-1:0]  alu_out;
      logic [DATA_W-1:0]  bus_b;
      logic [PC_W-1:0]    pc;
      logic [RADDR_W-1:0] wr_reg;
      logic               mem_wr;
      logic               mem_rd;
      logic               reg_wr;
      logic [SEL_W-1:0]   mem_to_reg;
      logic [SEL_W-1:0]   reg_dst;
   } exmem_payload_t;

   function automatic int payload_w(
      input int dw,
      input int pw,
      input int rw,
      input int sw
   );
      return 2*dw + pw + rw + 3 + 2*sw;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer (main + skid) with sync flush.
// in_ready depends only on registered state.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         m_v;
   logic         s_v;
   logic [W-1:0] m_d;
   logic [W-1:0] s_d;
   logic         acc;
   logic         m_free;
   logic         m_ld;
   logic         s_ld;

   assign in_ready  = !s_v;
   assign acc       = in_valid & !s_v;
   assign m_free    = !m_v | out_ready;
   assign m_ld      = !flush & m_free & (s_v | acc);
   assign s_ld      = !flush & !m_free & acc;
   assign out_valid = m_v;
   assign out_data  = m_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
      end else if (flush) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
      end else if (m_free) begin
         m_v <= s_v | acc;
         s_v <= 1'b0;
      end else if (acc) begin
         s_v <= 1'b1;
      end
   end

   // Skid always drains into main first, keeping strict FIFO order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_d <= '0;
         s_d <= '0;
      end else begin
         if (m_ld) m_d <= s_v ? s_d : in_data;
         if (s_ld) s_d <= in_data;
      end
   end

endmodule

// File: rtl/exmem_stage_reg.sv
// EX->MEM stage register: skid-buffered handshake, flush, strobe gating.
// Optional stall/flush counters when EXMEM_STAT_EN is defined.
module exmem_stage_reg #(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 32,
   parameter int RADDR_W = 5,
   parameter int SEL_W   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [DATA_W-1:0]  ex_alu_out,
   input  logic [DATA_W-1:0]  ex_bus_b,
   input  logic [PC_W-1:0]    ex_pc,
   input  logic [RADDR_W-1:0] ex_wr_reg,
   input  logic               ex_mem_wr,
   input  logic               ex_mem_rd,
   input  logic               ex_reg_wr,
   input  logic [SEL_W-1:0]   ex_mem_to_reg,
   input  logic [SEL_W-1:0]   ex_reg_dst,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic [DATA_W-1:0]  mem_alu_out,
   output logic [DATA_W-1:0]  mem_bus_b,
   output logic [PC_W-1:0]    mem_pc,
   output logic [RADDR_W-1:0] mem_wr_reg,
   output logic [SEL_W-1:0]   mem_mem_to_reg,
   output logic [SEL_W-1:0]   mem_reg_dst,
   output logic               mem_mem_wr,
   output logic               mem_mem_rd,
`ifdef EXMEM_STAT_EN
   output logic [31:0]        stall_cnt,
   output logic [15:0]        flush_cnt,
`endif
   output logic               mem_reg_wr
);

   import mips_pkg::payload_w;

   localparam int PW = payload_w(DATA_W, PC_W, RADDR_W, SEL_W);

   logic [PW-1:0] in_d;
   logic [PW-1:0] out_d;
   logic          raw_wr;
   logic          raw_rd;
   logic          raw_rw;

   assign in_d = {ex_alu_out, ex_bus_b, ex_pc, ex_wr_reg,
                  ex_mem_wr, ex_mem_rd, ex_reg_wr,
                  ex_mem_to_reg, ex_reg_dst};

   assign {mem_alu_out, mem_bus_b, mem_pc, mem_wr_reg,
           raw_wr, raw_rd, raw_rw,
           mem_mem_to_reg, mem_reg_dst} = out_d;

   // Held payload is stale once invalid; strobes must never leak it.
   assign mem_mem_wr = raw_wr & mem_valid;
   assign mem_mem_rd = raw_rd & mem_valid;
   assign mem_reg_wr = raw_rw & mem_valid;

   pipe_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (ex_valid),
      .in_ready  (ex_ready),
      .in_data   (in_d),
      .out_valid (mem_valid),
      .out_ready (mem_ready),
      .out_data  (out_d)
   );

`ifdef EXMEM_STAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (mem_valid && !mem_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         // Skid is occupied exactly when ex_ready is low.
         if (flush && (mem_valid || !ex_ready) && flush_cnt != '1)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
